// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit shifter and its parity generator.
//   - OversampleDefault : default sample_tick pulses per bit time
//   - Wls5..Wls8        : word length select encodings
//   - tx_state_t        : transmit shifter FSM states
//   - tx_cfg_t          : per-character line configuration captured at load
package uart_pkg;

    localparam int unsigned OversampleDefault = 16;

    localparam logic [1:0] Wls5 = 2'b00;
    localparam logic [1:0] Wls6 = 2'b01;
    localparam logic [1:0] Wls7 = 2'b10;
    localparam logic [1:0] Wls8 = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    typedef struct packed {
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       eps;
        logic       sp;
    } tx_cfg_t;

    // Index of the last data bit for a word length select (4..7).
    function automatic logic [2:0] last_data_bit(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// UART parity generator, purely combinational.
// Only the wls+5 active data bits take part; unused upper bits are masked off.
// Ports:
//   data_i   : character, LSB first on the line
//   wls_i    : word length select (00=5 .. 11=8 bits)
//   eps_i    : even parity select
//   sp_i     : stick parity (parity bit forced to ~eps_i)
//   parity_o : parity bit to transmit (or to compare against on receive)
module uart_parity_gen
    import uart_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [1:0] wls_i,
    input  logic       eps_i,
    input  logic       sp_i,
    output logic       parity_o
);

    logic [7:0] mask;
    logic       data_xor;

    always_comb begin
        mask = 8'hFF;
        unique case (wls_i)
            Wls5: mask = 8'h1F;
            Wls6: mask = 8'h3F;
            Wls7: mask = 8'h7F;
            Wls8: mask = 8'hFF;
        endcase
    end

    assign data_xor = ^(data_i & mask);

    always_comb begin
        if (sp_i) begin
            parity_o = ~eps_i;
        end else if (eps_i) begin
            parity_o = data_xor;
        end else begin
            parity_o = ~data_xor;
        end
    end

endmodule

// File: rtl/uart_tx_shifter.sv
// UART transmit shift register.
// Pops characters from the TX buffer and serialises them as
// start / 5-8 data bits LSB first / optional parity / 1, 1.5 or 2 stop bits.
// Bit timing is counted in external sample_tick pulses, OVERSAMPLE per bit.
// Ports:
//   pclk, presetn  : clock, synchronous active-low reset
//   sample_tick    : oversampling enable from the baud generator
//   tx_data        : head of TX buffer, valid while tx_fifo_empty is low
//   tx_fifo_empty  : TX buffer has no character
//   wls/stb/pen/eps/sp : line configuration, captured per character
//   bc             : break control, forces txd low while asserted
//   tsr_load       : registered one-cycle pop strobe to the TX buffer
//   txd            : registered serial output, idles high
//   tx_busy        : a character is in flight
//   temt           : buffer empty and shifter idle
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OversampleDefault
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       sample_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_fifo_empty,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       bc,
    output logic       tsr_load,
    output logic       txd,
    output logic       tx_busy,
    output logic       temt
);

    // One extra counter bit so the 1.5 and 2 stop-bit periods fit.
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned CntW  = TickW + 1;

    localparam logic [CntW-1:0] BitLast    = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] Stop15Last = CntW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] Stop2Last  = CntW'(2 * OVERSAMPLE - 1);

    tx_state_t       state_q, state_d;
    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    tx_cfg_t         cfg_q, cfg_d;
    logic            txd_q, txd_d;
    logic            tsr_load_q, tsr_load_d;

    logic [CntW-1:0] tick_last;
    logic            bit_done;
    logic            data_done;
    logic            load;
    logic            parity_bit;
    logic            line;

    // Parity is taken from the unshifted copy of the character.
    uart_parity_gen u_parity_gen (
        .data_i   (data_q),
        .wls_i    (cfg_q.wls),
        .eps_i    (cfg_q.eps),
        .sp_i     (cfg_q.sp),
        .parity_o (parity_bit)
    );

    // Last tick index of the bit currently on the line.
    always_comb begin
        tick_last = BitLast;
        if (state_q == StStop && cfg_q.stb) begin
            tick_last = (cfg_q.wls == Wls5) ? Stop15Last : Stop2Last;
        end
    end

    assign bit_done  = sample_tick & (tick_cnt_q == tick_last);
    assign data_done = (bit_cnt_q == last_data_bit(cfg_q.wls));

    // Pop from idle, or chain the next character straight off the last stop tick.
    assign load = ~tx_fifo_empty &
                  ((state_q == StIdle) | ((state_q == StStop) & bit_done));

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!tx_fifo_empty) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done && data_done) begin
                    state_d = cfg_q.pen ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    state_d = tx_fifo_empty ? StIdle : StStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        line = 1'b1;
        unique case (state_q)
            StIdle:   line = 1'b1;
            StStart:  line = 1'b0;
            StData:   line = shift_q[0];
            StParity: line = parity_bit;
            StStop:   line = 1'b1;
            default:  line = 1'b1;
        endcase
        // Break is applied on the output only, so frame timing is unaffected.
        txd_d      = line & ~bc;
        tsr_load_d = load;
    end

    // ---------------------------------------------------------------
    // Datapath next state: tick / bit counters, shifter, shadow config
    // ---------------------------------------------------------------
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        cfg_d      = cfg_q;

        if (state_q == StIdle) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (bit_done) begin
            tick_cnt_d = '0;
            if (state_q == StData) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = {1'b0, shift_q[7:1]};
            end
        end else if (sample_tick) begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
        end

        if (load) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = tx_data;
            data_d     = tx_data;
            cfg_d      = '{wls: wls, stb: stb, pen: pen, eps: eps, sp: sp};
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            cfg_q      <= '0;
            txd_q      <= 1'b1;
            tsr_load_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            txd_q      <= txd_d;
            tsr_load_q <= tsr_load_d;
        end
    end

    assign txd      = txd_q;
    assign tsr_load = tsr_load_q;
    assign tx_busy  = (state_q != StIdle);
    assign temt     = tx_fifo_empty & ~tx_busy;

endmodule

// File: tb/tb_uart_tx_shifter.sv
module tb_uart_tx_shifter;

    localparam int Os = 16;

    logic       pclk;
    logic       presetn;
    logic       sample_tick;
    logic [7:0] tx_data;
    logic       tx_fifo_empty;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       bc;
    logic       tsr_load;
    logic       txd;
    logic       tx_busy;
    logic       temt;

    uart_tx_shifter #(
        .OVERSAMPLE (Os)
    ) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .sample_tick   (sample_tick),
        .tx_data       (tx_data),
        .tx_fifo_empty (tx_fifo_empty),
        .wls           (wls),
        .stb           (stb),
        .pen           (pen),
        .eps           (eps),
        .sp            (sp),
        .bc            (bc),
        .tsr_load      (tsr_load),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .temt          (temt)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40) begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------------------------------------------------------
    // TX buffer: pops on the edge after tsr_load was seen high
    // ---------------------------------------------------------------
    logic [7:0] fifo[$];
    logic       pop_pending = 1'b0;
    int         tick_div    = 1;
    int         tick_phase  = 0;

    task automatic drive_fifo();
        tx_fifo_empty = (fifo.size() == 0);
        tx_data       = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        fifo.push_back(d);
        drive_fifo();
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        if (pop_pending) begin
            if (fifo.size() != 0) void'(fifo.pop_front());
            pop_pending = 1'b0;
        end
        if (tsr_load) pop_pending = 1'b1;
        drive_fifo();
        tick_phase  = (tick_phase + 1) % tick_div;
        sample_tick = (tick_phase == 0);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic s, input logic p,
                           input logic e, input logic st);
        wls = w;
        stb = s;
        pen = p;
        eps = e;
        sp  = st;
    endtask

    // ---------------------------------------------------------------
    // Reference model: a frame is a list of (level, length-in-ticks)
    // segments built from the line rules when a character is taken.
    // ---------------------------------------------------------------
    logic seg_val[$];
    int   seg_len[$];
    logic m_busy   = 1'b0;
    logic m_load   = 1'b0;
    logic model_ok = 1'b0;
    logic exp_txd, exp_load, exp_busy;

    task automatic build_frame();
        int   nbits;
        int   ones;
        int   stop_ticks;
        logic par;
        nbits = int'(wls) + 5;
        ones  = 0;
        seg_val.push_back(1'b0);
        seg_len.push_back(Os);
        for (int i = 0; i < nbits; i++) begin
            seg_val.push_back(tx_data[i]);
            seg_len.push_back(Os);
            if (tx_data[i]) ones++;
        end
        if (pen) begin
            if (sp) par = ~eps;
            else if (eps) par = (ones % 2 == 1);
            else par = (ones % 2 == 0);
            seg_val.push_back(par);
            seg_len.push_back(Os);
        end
        if (!stb) stop_ticks = Os;
        else if (wls == 2'b00) stop_ticks = Os * 3 / 2;
        else stop_ticks = 2 * Os;
        seg_val.push_back(1'b1);
        seg_len.push_back(stop_ticks);
        m_busy = 1'b1;
    endtask

    always @(posedge pclk) begin
        if (!presetn) begin
            seg_val.delete();
            seg_len.delete();
            m_busy   = 1'b0;
            exp_txd  = 1'b1;
            exp_load = 1'b0;
            exp_busy = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_load  = 1'b0;
            exp_txd = (m_busy ? seg_val[0] : 1'b1) & ~bc;
            if (!m_busy) begin
                if (!tx_fifo_empty) begin
                    build_frame();
                    m_load = 1'b1;
                end
            end else if (sample_tick) begin
                seg_len[0] = seg_len[0] - 1;
                if (seg_len[0] == 0) begin
                    void'(seg_val.pop_front());
                    void'(seg_len.pop_front());
                    if (seg_val.size() == 0) begin
                        m_busy = 1'b0;
                        if (!tx_fifo_empty) begin
                            build_frame();
                            m_load = 1'b1;
                        end
                    end
                end
            end
            exp_load = m_load;
            exp_busy = m_busy;
        end
    end

    always @(negedge pclk) begin
        if (model_ok) begin
            check("cycle txd", 32'(txd), 32'(exp_txd));
            check("cycle tsr_load", 32'(tsr_load), 32'(exp_load));
            check("cycle tx_busy", 32'(tx_busy), 32'(exp_busy));
            check("cycle temt", 32'(temt), 32'(tx_fifo_empty & ~exp_busy));
        end
    end

    // ---------------------------------------------------------------
    // Directed helpers
    // ---------------------------------------------------------------
    task automatic wait_load(input string name);
        int n;
        n = 0;
        while (!tsr_load && n < 50) begin
            step();
            n++;
        end
        check({name, " load seen"}, 32'(tsr_load), 32'd1);
    endtask

    // Called in the cycle tsr_load is high; samples bit k mid-bit (16 cycles/bit).
    task automatic run_frame(input int nbits, output logic [15:0] bits,
                             output int busy, output int loads);
        int j;
        bits  = '0;
        busy  = 1;
        loads = 1;
        j     = 0;
        while (tx_busy && j < 3000) begin
            step();
            j++;
            for (int k = 0; k < nbits; k++) begin
                if (j == 9 + 16 * k) bits[k] = txd;
            end
            if (tx_busy) busy++;
            if (tsr_load) loads++;
        end
        check("frame end within budget", 32'(j < 3000), 32'd1);
    endtask

    task automatic adv(input int n, inout int busy);
        for (int i = 0; i < n; i++) begin
            step();
            if (tx_busy) busy++;
        end
    endtask

    task automatic run_until_idle(inout int busy);
        int j;
        j = 0;
        while (tx_busy && j < 3000) begin
            step();
            j++;
            if (tx_busy) busy++;
        end
        check("idle within budget", 32'(j < 3000), 32'd1);
    endtask

    task automatic do_frame(input string name, input logic [7:0] d, input int nbits,
                            input logic [15:0] exp_bits, input int exp_busy_cyc);
        logic [15:0] bits;
        int          busy;
        int          loads;
        push(d);
        wait_load(name);
        run_frame(nbits, bits, busy, loads);
        check({name, " bits"}, 32'(bits), 32'(exp_bits));
        check({name, " busy cycles"}, 32'(busy), 32'(exp_busy_cyc));
        check({name, " tsr_load count"}, 32'(loads), 32'd1);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        int          busy;
        int          loads;
        int          extra;

        presetn     = 1'b0;
        bc          = 1'b0;
        sample_tick = 1'b1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_fifo();
        repeat (3) step();
        check("reset txd", 32'(txd), 32'd1);
        check("reset tsr_load", 32'(tsr_load), 32'd0);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        check("reset temt", 32'(temt), 32'd1);
        presetn = 1'b1;
        repeat (2) step();

        // 1: 8N1, 0x55
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame("8N1 0x55", 8'h55, 10, 16'b1010101010, 160);
        check("8N1 temt after frame", 32'(temt), 32'd1);

        // 2: 7E1 / 7O1 / stick parity, 0x41
        set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        do_frame("7E1 0x41", 8'h41, 10, 16'b1010000010, 160);
        set_cfg(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        do_frame("7O1 0x41", 8'h41, 10, 16'b1110000010, 160);
        set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        do_frame("7 stick eps1 0x41", 8'h41, 10, 16'b1010000010, 160);

        // 3: 5-bit with 1.5 stop bits; upper data bits ignored
        set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        do_frame("5N1.5 0x1F", 8'h1F, 6, 16'b111110, 120);
        do_frame("5N1.5 0xFF", 8'hFF, 6, 16'b111110, 120);
        set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        do_frame("5E1.5 0xE3", 8'hE3, 7, 16'b0000110, 136);

        // 4: back-to-back characters, no idle bit between frames
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h55);
        push(8'hA5);
        wait_load("b2b");
        run_frame(11, bits, busy, loads);
        check("b2b bits", 32'(bits), 32'b01010101010);
        check("b2b busy cycles", 32'(busy), 32'd320);
        check("b2b tsr_load count", 32'(loads), 32'd2);
        step();

        // 5a: break mid-DATA leaves bit timing intact
        push(8'h55);
        wait_load("break");
        busy = 1;
        adv(40, busy);
        bc = 1'b1;
        adv(1, busy);
        check("break forces low", 32'(txd), 32'd0);
        adv(20, busy);
        check("break holds low", 32'(txd), 32'd0);
        bc = 1'b0;
        adv(1, busy);
        check("break release data bit 2", 32'(txd), 32'd1);
        run_until_idle(busy);
        check("break busy cycles", 32'(busy), 32'd160);
        step();

        // 5b: reset while in PARITY
        set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        push(8'h41);
        wait_load("reset in parity");
        busy = 1;
        adv(133, busy);
        presetn = 1'b0;
        step();
        check("parity reset txd", 32'(txd), 32'd1);
        check("parity reset tx_busy", 32'(tx_busy), 32'd0);
        check("parity reset tsr_load", 32'(tsr_load), 32'd0);
        presetn = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tsr_load) extra++;
        end
        check("no load after reset", 32'(extra), 32'd0);
        check("temt after reset", 32'(temt), 32'd1);

        // 6: tick every 4th cycle; wls change mid-frame ignored
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_div = 4;
        push(8'h55);
        wait_load("slow tick");
        busy = 1;
        adv(100, busy);
        wls = 2'b00;
        run_until_idle(busy);
        check("slow tick busy in 637..640", 32'(busy >= 637 && busy <= 640), 32'd1);
        wls         = 2'b11;
        tick_div    = 1;
        tick_phase  = 0;
        sample_tick = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
